sequentializer_ctrl: RTL
========================

Name: sequentializer_ctrl

Overview:
- Frame-level scheduler for the burst-to-pixel sequentializer.
- Arms on a software start, waits for each camera start-of-frame, and issues one ap_start pulse per frame.
- Tracks pixel handshakes against the expected frame size and watchdogs stalls. On a stall or an abort it resets the sequentializer.
- Counts completed frames and reports sticky error flags to the CustomLogic control/status registers.

Parameters:
IN_ROWS, 20, frame rows seen by the sequentializer
IN_COLS, 20, frame columns seen by the sequentializer
FRAME_CNT_W, 16, width of the frame-count config and status
TIMEOUT_W, 24, width of the watchdog config
RECOVER_CYCLES, 4, number of cycles seq_srst is held during recovery

Ports:
clk  in  1  system clock
srst  in  1  synchronous reset, active-high
cfg_start  in  1  pulse; arms a run (ignored unless IDLE)
cfg_abort  in  1  pulse; terminates the run
cfg_num_frames  in  FRAME_CNT_W  frames per run; 0 = continuous
cfg_timeout  in  TIMEOUT_W  stall limit in cycles; 0 = watchdog off
sof  in  1  start-of-frame pulse from acquisition
seq_ap_start  out  1  one-cycle start pulse to the sequentializer
seq_ap_done  in  1  done pulse from the sequentializer
seq_px_hs  in  1  sequentializer m_axis_tvalid && m_axis_tready
seq_srst  out  1  extra reset to the sequentializer; the top ORs it with srst
busy  out  1  high in every state except IDLE
frames_done  out  FRAME_CNT_W  frames completed in the current/last run
run_done  out  1  one-cycle pulse when a finite run completes
err_timeout  out  1  sticky; watchdog fired
err_length  out  1  sticky; pixel count at ap_done differed from FRAME_PIXELS
err_sof_overrun  out  1  sticky; sof arrived while a frame was in flight

Behaviour:
- FRAME_PIXELS = IN_ROWS*IN_COLS. The pixel counter is $clog2(FRAME_PIXELS+1) bits wide and saturates at FRAME_PIXELS.
- Reset: state=IDLE; all outputs 0; frames_done=0; all counters 0; all error flags 0.
- States: IDLE, WAIT_SOF, START, RUN, RECOVER, FINISH.
- IDLE:
  - cfg_start -> WAIT_SOF next cycle; frames_done and all error flags clear on that edge.
  - sof is ignored.
- WAIT_SOF:
  - sof -> START.
  - cfg_abort -> IDLE directly; no seq_srst is asserted, because no frame is in flight.
- START:
  - seq_ap_start=1 for exactly this one cycle.
  - Pixel counter and watchdog counter clear.
  - Unconditionally -> RUN.
- RUN:
  - Each seq_px_hs increments the pixel counter and clears the watchdog counter.
  - The watchdog counter increments on every cycle without seq_px_hs.
  - On seq_ap_done:
    - err_length is set if pixel count != FRAME_PIXELS.
    - frames_done increments.
    - If cfg_num_frames!=0 and the new frames_done==cfg_num_frames -> FINISH; otherwise -> WAIT_SOF.
  - Timeout: cfg_timeout!=0 and watchdog==cfg_timeout-1 with no seq_px_hs that cycle. Result: err_timeout set, abort_reason=0 (continue), -> RECOVER. The frame is not counted.
  - cfg_abort: abort_reason=1 (stop), -> RECOVER.
- Priority in RUN when events coincide: seq_ap_done > cfg_abort > timeout.
  - If seq_ap_done and cfg_abort coincide, the frame is counted and the block then goes to RECOVER with abort_reason=1.
- RECOVER:
  - seq_srst=1 for exactly RECOVER_CYCLES cycles.
  - Then -> IDLE if abort_reason=1, otherwise -> WAIT_SOF.
  - cfg_abort during RECOVER sets abort_reason=1.
- FINISH:
  - run_done=1 for one cycle, then -> IDLE.
  - frames_done holds its value until the next cfg_start.
- sof in START, RUN or RECOVER sets err_sof_overrun. That frame is dropped and never queued.
- cfg_start outside IDLE is ignored.
- srst mid-run overrides everything: return to reset values on the next edge.
- frames_done wraps modulo 2^FRAME_CNT_W in continuous mode.

Decomposition:
- Package seq_ctrl_pkg holds:
  - the state enum (seq_ctrl_state_t);
  - localparam-style function frame_pixels(rows, cols);
  - the recovery reason typedef.
- One sub-module, seq_watchdog: a cycle counter with clear/enable inputs, a limit input, a zero-disables rule, and a one-cycle expire output.
- The FSM and counters stay in sequentializer_ctrl.

Test Plan:
Bench configuration for all scenarios: IN_ROWS=4, IN_COLS=4 (FRAME_PIXELS=16), RECOVER_CYCLES=4.
1. Normal finite run:
   - Stimulus: cfg_num_frames=2, cfg_start, then per frame sof, 16 seq_px_hs, seq_ap_done.
   - Required: two single-cycle seq_ap_start pulses, each exactly one cycle after its sof; frames_done=2; run_done pulse; no errors; busy falls one cycle after run_done.
2. Length error:
   - Stimulus: one frame with 15 seq_px_hs then seq_ap_done.
   - Required: err_length=1; frames_done=1; next sof is still accepted.
3. Timeout recovery:
   - Stimulus: cfg_timeout=10, sof, 3 seq_px_hs, then silence.
   - Required: err_timeout=1 exactly 10 cycles after the last hs; seq_srst high 4 cycles; state returns to WAIT_SOF; frames_done unchanged; next frame completes normally.
4. Abort mid-frame:
   - Stimulus: cfg_abort while in RUN.
   - Required: seq_srst high 4 cycles; then IDLE with busy=0; no run_done.
   - Variant: abort coincident with seq_ap_done -> frames_done increments, then the same recovery sequence.
5. SOF overrun and ignored start:
   - Stimulus: sof during RUN; cfg_start during RUN.
   - Required: err_sof_overrun=1; no second seq_ap_start; run proceeds unaffected.
6. Continuous mode and reset:
   - Stimulus: cfg_num_frames=0 for 5 frames, then srst asserted mid-frame.
   - Required: frames_done=5 before reset; all outputs 0 and state IDLE on the cycle after srst.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// rtl/seq_ctrl_pkg.sv - shared types and helpers for the sequentializer frame scheduler
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_START,
        ST_RUN,
        ST_RECOVER,
        ST_FINISH
    } seq_ctrl_state_t;

    typedef enum logic {
        REASON_CONTINUE = 1'b0,
        REASON_STOP     = 1'b1
    } recover_reason_t;

    function automatic int unsigned frame_pixels(input int unsigned rows, input int unsigned cols);
        return rows * cols;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - stall counter; expires when the limit is reached, limit of zero disables it
module seq_watchdog #(
    parameter int W = 24
) (
    input  logic         clk_i,
    input  logic         srst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         expire_o
);

    logic [W-1:0] count_q;

    // Combinational so the owner can act in the same cycle the limit is reached.
    assign expire_o = en_i && (limit_i != '0) && (count_q == (limit_i - W'(1)));

    always_ff @(posedge clk_i) begin
        if (srst_i || clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

endmodule

// File: rtl/sequentializer_ctrl.sv
// rtl/sequentializer_ctrl.sv - frame-level scheduler: arms per run, starts one sequentializer pass per sof,
// checks frame length, watchdogs stalls and recovers the sequentializer with seq_srst.
module sequentializer_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int IN_ROWS        = 20,
    parameter int IN_COLS        = 20,
    parameter int FRAME_CNT_W    = 16,
    parameter int TIMEOUT_W      = 24,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   cfg_start,
    input  logic                   cfg_abort,
    input  logic [FRAME_CNT_W-1:0] cfg_num_frames,
    input  logic [TIMEOUT_W-1:0]   cfg_timeout,
    input  logic                   sof,
    output logic                   seq_ap_start,
    input  logic                   seq_ap_done,
    input  logic                   seq_px_hs,
    output logic                   seq_srst,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frames_done,
    output logic                   run_done,
    output logic                   err_timeout,
    output logic                   err_length,
    output logic                   err_sof_overrun
);

    localparam int unsigned FRAME_PIXELS = frame_pixels(IN_ROWS, IN_COLS);
    localparam int PIX_W = $clog2(FRAME_PIXELS + 1);
    localparam int REC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [PIX_W-1:0] PIX_FULL = PIX_W'(FRAME_PIXELS);
    localparam logic [REC_W-1:0] REC_LAST = REC_W'(RECOVER_CYCLES - 1);

    seq_ctrl_state_t        state_q, state_d;
    recover_reason_t        reason_q, reason_d;
    logic [PIX_W-1:0]       pix_q, pix_d;
    logic [REC_W-1:0]       rec_q, rec_d;
    logic [FRAME_CNT_W-1:0] frames_q, frames_d;
    logic                   err_to_q, err_to_d;
    logic                   err_len_q, err_len_d;
    logic                   err_ovr_q, err_ovr_d;
    logic                   ap_start_q, srst_out_q, busy_q, run_done_q;

    logic                   wd_clr, wd_en, wd_expire;
    logic [PIX_W-1:0]       pix_inc, pix_now;
    logic [FRAME_CNT_W-1:0] frames_inc;

    assign wd_clr = (state_q == ST_START) || ((state_q == ST_RUN) && seq_px_hs);
    assign wd_en  = (state_q == ST_RUN) && !seq_px_hs;

    seq_watchdog #(
        .W (TIMEOUT_W)
    ) u_watchdog (
        .clk_i    (clk),
        .srst_i   (srst),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .limit_i  (cfg_timeout),
        .expire_o (wd_expire)
    );

    assign pix_inc    = (pix_q == PIX_FULL) ? pix_q : pix_q + PIX_W'(1);
    assign pix_now    = seq_px_hs ? pix_inc : pix_q;
    assign frames_inc = frames_q + FRAME_CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        reason_d  = reason_q;
        pix_d     = pix_q;
        rec_d     = '0;
        frames_d  = frames_q;
        err_to_d  = err_to_q;
        err_len_d = err_len_q;
        err_ovr_d = err_ovr_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d   = ST_WAIT_SOF;
                    reason_d  = REASON_CONTINUE;
                    frames_d  = '0;
                    err_to_d  = 1'b0;
                    err_len_d = 1'b0;
                    err_ovr_d = 1'b0;
                end
            end
            ST_WAIT_SOF: begin
                if (cfg_abort) begin
                    state_d = ST_IDLE;
                end else if (sof) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                pix_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                pix_d = pix_now;
                // A handshake in the same cycle as ap_done belongs to the finishing frame.
                if (seq_ap_done) begin
                    frames_d = frames_inc;
                    if (pix_now != PIX_FULL) begin
                        err_len_d = 1'b1;
                    end
                    if (cfg_abort) begin
                        reason_d = REASON_STOP;
                        state_d  = ST_RECOVER;
                    end else if ((cfg_num_frames != '0) && (frames_inc == cfg_num_frames)) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_WAIT_SOF;
                    end
                end else if (cfg_abort) begin
                    reason_d = REASON_STOP;
                    state_d  = ST_RECOVER;
                end else if (wd_expire) begin
                    err_to_d = 1'b1;
                    reason_d = REASON_CONTINUE;
                    state_d  = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                rec_d = rec_q + REC_W'(1);
                if (cfg_abort) begin
                    reason_d = REASON_STOP;
                end
                if (rec_q == REC_LAST) begin
                    rec_d   = '0;
                    state_d = ((reason_q == REASON_STOP) || cfg_abort) ? ST_IDLE : ST_WAIT_SOF;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A sof while a frame is in flight is dropped, only flagged.
        if (sof && ((state_q == ST_START) || (state_q == ST_RUN) || (state_q == ST_RECOVER))) begin
            err_ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= ST_IDLE;
            reason_q   <= REASON_CONTINUE;
            pix_q      <= '0;
            rec_q      <= '0;
            frames_q   <= '0;
            err_to_q   <= 1'b0;
            err_len_q  <= 1'b0;
            err_ovr_q  <= 1'b0;
            ap_start_q <= 1'b0;
            srst_out_q <= 1'b0;
            busy_q     <= 1'b0;
            run_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            reason_q   <= reason_d;
            pix_q      <= pix_d;
            rec_q      <= rec_d;
            frames_q   <= frames_d;
            err_to_q   <= err_to_d;
            err_len_q  <= err_len_d;
            err_ovr_q  <= err_ovr_d;
            ap_start_q <= (state_d == ST_START);
            srst_out_q <= (state_d == ST_RECOVER);
            busy_q     <= (state_d != ST_IDLE);
            run_done_q <= (state_d == ST_FINISH);
        end
    end

    assign seq_ap_start    = ap_start_q;
    assign seq_srst        = srst_out_q;
    assign busy            = busy_q;
    assign run_done        = run_done_q;
    assign frames_done     = frames_q;
    assign err_timeout     = err_to_q;
    assign err_length      = err_len_q;
    assign err_sof_overrun = err_ovr_q;

endmodule
